// File: rtl/mux_pipe_stage_pkg.sv
// Shared widths, select-width helper and beat record for the operand selector stage.
package mux_pkg;

    localparam int MUX_W_DATA = 32;
    localparam int MUX_W_REG  = 5;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [MUX_W_DATA-1:0] data;
        logic [MUX_W_REG-1:0]  sel;
        logic                  err;
    } beat_t;

endpackage

// File: rtl/mux_pipe_stage_if.sv
// Producer/consumer handshake bundle for mux_pipe_stage; slave is the stage side.
interface mux_pipe_stage_if
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_W_DATA,
    parameter int N_IN  = 4
);
    localparam int SEL_W = sel_w(N_IN);

    logic [N_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]      sel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;

    modport master (
        output in_bus, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err
    );

    modport slave (
        input  in_bus, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err
    );

endinterface

// File: rtl/mux_pipe_stage_nway.sv
// Combinational N_IN:1 channel select; out-of-range select yields DEFAULT_VAL.
module mux_nway #(
    parameter int               WIDTH       = 32,
    parameter int               N_IN        = 4,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic [N_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]      sel,
`ifdef MUX_SEL_ERR_EN
    output logic                  out_of_range,
`endif
    output logic [WIDTH-1:0]      data
);

    always_comb begin
        data = DEFAULT_VAL;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) data = in_bus[k*WIDTH +: WIDTH];
        end
    end

`ifdef MUX_SEL_ERR_EN
    assign out_of_range = (int'(sel) >= N_IN);
`endif

endmodule

// File: rtl/mux_pipe_stage.sv
// Registered N-way selector with 2-entry skid buffer, stall and flush.
// Define MUX_SEL_ERR_EN to carry a per-beat out-of-range select flag to sel_err.
module mux_pipe_stage
    import mux_pkg::*;
#(
    parameter int               WIDTH       = MUX_W_DATA,
    parameter int               N_IN        = 4,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    mux_pipe_stage_if.slave  bus
);

    localparam int SEL_W = sel_w(N_IN);

`ifdef MUX_SEL_ERR_EN
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } stage_beat_t;
`else
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
    } stage_beat_t;
`endif

    logic [WIDTH-1:0] mux_data;
    stage_beat_t      beat_in;
    stage_beat_t      main_q, main_n, skid_q, skid_n;
    logic             main_v_q, main_v_n, skid_v_q, skid_v_n;
    logic             in_ready_q;
    logic             accept, pop;

`ifdef MUX_SEL_ERR_EN
    logic             mux_err;

    mux_nway #(
        .WIDTH       (WIDTH),
        .N_IN        (N_IN),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_nway (
        .in_bus       (bus.in_bus),
        .sel          (bus.sel),
        .out_of_range (mux_err),
        .data         (mux_data)
    );

    assign beat_in.err = mux_err;
    assign bus.sel_err = main_q.err;
`else
    mux_nway #(
        .WIDTH       (WIDTH),
        .N_IN        (N_IN),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_nway (
        .in_bus (bus.in_bus),
        .sel    (bus.sel),
        .data   (mux_data)
    );

    assign bus.sel_err = 1'b0;
`endif

    assign beat_in.data = mux_data;
    assign beat_in.sel  = bus.sel;

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = main_v_q && bus.out_ready;

    // in_ready is never asserted while skid holds a beat, so skid-full never meets an accept.
    always_comb begin
        main_n   = main_q;
        main_v_n = main_v_q;
        skid_n   = skid_q;
        skid_v_n = skid_v_q;
        if (bus.flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (!main_v_q || pop) begin
            if (skid_v_q) begin
                main_n   = skid_q;
                main_v_n = 1'b1;
                skid_v_n = 1'b0;
            end else if (accept) begin
                main_n   = beat_in;
                main_v_n = 1'b1;
            end else begin
                main_v_n = 1'b0;
            end
        end else if (accept) begin
            skid_n   = beat_in;
            skid_v_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q     <= '0;
            main_v_q   <= 1'b0;
            skid_q     <= '0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_n;
            main_v_q   <= main_v_n;
            skid_q     <= skid_n;
            skid_v_q   <= skid_v_n;
            in_ready_q <= !skid_v_n;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_v_q;
    assign bus.out_data  = main_q.data;
    assign bus.out_sel   = main_q.sel;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Self-checking bench for mux_pipe_stage: vector tables plus a scoreboard on the 4-way instance.
module tb_mux_pipe_stage;
    import mux_pkg::*;

    localparam logic [31:0] DEF3 = 32'h5A5A_0F0F;
`ifdef MUX_SEL_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_pipe_stage_if #(.WIDTH(32), .N_IN(4)) b4();
    mux_pipe_stage_if #(.WIDTH(32), .N_IN(3)) b3();

    mux_pipe_stage #(.WIDTH(32), .N_IN(4), .DEFAULT_VAL(32'h0)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4.slave)
    );

    mux_pipe_stage #(.WIDTH(32), .N_IN(3), .DEFAULT_VAL(DEF3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3.slave)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  sel;
    } exp_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        err;
    } vec_t;

    exp_t        sbq[$];
    logic [31:0] drv_exp;
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          pops      = 0;
    vec_t        tab3[4];
    vec_t        tab4[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pops compare against the oldest expected beat, accepts push a new one.
    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        if (!reset) begin
            if (b4.out_valid && b4.out_ready) begin
                pops++;
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_beat", 64'(b4.out_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_data", 64'(b4.out_data), 64'(e.data));
                    chk("sb_sel", 64'(b4.out_sel), 64'(e.sel));
                end
            end
            if (b4.flush) begin
                sbq.delete();
            end else if (b4.in_valid && b4.in_ready) begin
                n.data = drv_exp;
                n.sel  = b4.sel;
                sbq.push_back(n);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        tab3[0] = '{2'd0, 32'hAA, 1'b0};
        tab3[1] = '{2'd2, 32'hCC, 1'b0};
        tab3[2] = '{2'd3, DEF3,   EXP_ERR};
        tab3[3] = '{2'd1, 32'hBB, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tab4[i].sel = 2'(i % 4);
            tab4[i].err = 1'b0;
        end
        tab4[0].data = 32'hAA; tab4[1].data = 32'hBB; tab4[2].data = 32'hCC; tab4[3].data = 32'hDD;
        tab4[4].data = 32'hAA; tab4[5].data = 32'hBB; tab4[6].data = 32'hCC; tab4[7].data = 32'hDD;

        reset = 1'b1;
        drv_exp = '0;
        b4.in_bus = {32'hDD, 32'hCC, 32'hBB, 32'hAA};
        b4.sel = '0; b4.in_valid = 1'b0; b4.flush = 1'b0; b4.out_ready = 1'b1;
        b3.in_bus = {32'hCC, 32'hBB, 32'hAA};
        b3.sel = '0; b3.in_valid = 1'b0; b3.flush = 1'b0; b3.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 64'(b4.out_valid), 64'd0);
        chk("rst_out_data", 64'(b4.out_data), 64'd0);
        chk("rst_out_sel", 64'(b4.out_sel), 64'd0);
        chk("rst_sel_err", 64'(b4.sel_err), 64'd0);
        chk("rst_in_ready", 64'(b4.in_ready), 64'd1);
        chk("rst3_out_valid", 64'(b3.out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // single beat, one-cycle latency
        b4.sel = 2'd2; b4.in_valid = 1'b1; drv_exp = 32'hCC;
        tick();
        b4.in_valid = 1'b0;
        chk("t1_out_valid", 64'(b4.out_valid), 64'd1);
        chk("t1_out_data", 64'(b4.out_data), 64'h0000_00CC);
        chk("t1_out_sel", 64'(b4.out_sel), 64'd2);
        chk("t1_sel_err", 64'(b4.sel_err), 64'd0);
        tick();
        chk("t1_drained", 64'(b4.out_valid), 64'd0);

        // 3-way instance, including the out-of-range select
        for (int i = 0; i < 4; i++) begin
            b3.sel = tab3[i].sel; b3.in_valid = 1'b1;
            tick();
            chk("t2_out_valid", 64'(b3.out_valid), 64'd1);
            chk("t2_out_data", 64'(b3.out_data), 64'(tab3[i].data));
            chk("t2_out_sel", 64'(b3.out_sel), 64'(tab3[i].sel));
            chk("t2_sel_err", 64'(b3.sel_err), 64'(tab3[i].err));
        end
        b3.in_valid = 1'b0;
        tick();
        chk("t2_drained", 64'(b3.out_valid), 64'd0);

        // backpressure fills skid, third beat held off until release
        p0 = pops;
        b4.out_ready = 1'b0;
        b4.sel = 2'd0; b4.in_valid = 1'b1; drv_exp = 32'hAA;
        tick();
        chk("t3_ready_after_1", 64'(b4.in_ready), 64'd1);
        b4.sel = 2'd1; drv_exp = 32'hBB;
        tick();
        chk("t3_ready_after_2", 64'(b4.in_ready), 64'd0);
        b4.sel = 2'd2; drv_exp = 32'hCC;
        tick();
        chk("t3_ready_held", 64'(b4.in_ready), 64'd0);
        chk("t3_data_stable", 64'(b4.out_data), 64'h0000_00AA);
        chk("t3_valid_stable", 64'(b4.out_valid), 64'd1);
        b4.out_ready = 1'b1;
        tick();
        chk("t3_skid_to_main", 64'(b4.out_data), 64'h0000_00BB);
        tick();
        b4.in_valid = 1'b0;
        chk("t3_third_beat", 64'(b4.out_data), 64'h0000_00CC);
        tick();
        chk("t3_pop_count", 64'(pops - p0), 64'd3);
        chk("t3_sb_empty", 64'(sbq.size()), 64'd0);

        // streaming at full rate
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            b4.sel = tab4[i].sel; b4.in_valid = 1'b1; drv_exp = tab4[i].data;
            tick();
            chk("t4_out_valid", 64'(b4.out_valid), 64'd1);
            chk("t4_out_data", 64'(b4.out_data), 64'(tab4[i].data));
            chk("t4_in_ready", 64'(b4.in_ready), 64'd1);
        end
        b4.in_valid = 1'b0;
        tick();
        chk("t4_pop_count", 64'(pops - p0), 64'd8);
        chk("t4_sb_empty", 64'(sbq.size()), 64'd0);

        // flush with both entries held
        b4.out_ready = 1'b0;
        b4.sel = 2'd0; b4.in_valid = 1'b1; drv_exp = 32'hAA;
        tick();
        b4.sel = 2'd1; drv_exp = 32'hBB;
        tick();
        chk("t5_skid_full", 64'(b4.in_ready), 64'd0);
        b4.sel = 2'd3; drv_exp = 32'hDD; b4.flush = 1'b1;
        tick();
        b4.flush = 1'b0; b4.in_valid = 1'b0;
        chk("t5_out_valid", 64'(b4.out_valid), 64'd0);
        chk("t5_in_ready", 64'(b4.in_ready), 64'd1);
        b4.out_ready = 1'b1;
        // flush wins over a same-cycle accept into an empty stage
        b4.sel = 2'd3; b4.in_valid = 1'b1; b4.flush = 1'b1; drv_exp = 32'hDD;
        tick();
        b4.flush = 1'b0; b4.in_valid = 1'b0;
        chk("t5_flush_drop", 64'(b4.out_valid), 64'd0);
        tick();
        chk("t5_nothing_later", 64'(b4.out_valid), 64'd0);

        // async reset while both entries are held
        b4.out_ready = 1'b0;
        b4.sel = 2'd0; b4.in_valid = 1'b1; drv_exp = 32'hAA;
        tick();
        b4.sel = 2'd1; drv_exp = 32'hBB;
        tick();
        b4.in_valid = 1'b0;
        chk("t6_pre_valid", 64'(b4.out_valid), 64'd1);
        chk("t6_pre_ready", 64'(b4.in_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        sbq.delete();
        chk("t6_out_valid", 64'(b4.out_valid), 64'd0);
        chk("t6_in_ready", 64'(b4.in_ready), 64'd1);
        chk("t6_out_data", 64'(b4.out_data), 64'd0);
        chk("t6_out_sel", 64'(b4.out_sel), 64'd0);
        tick();
        reset = 1'b0;
        b4.out_ready = 1'b1;
        tick();
        chk("t6_no_survivor", 64'(b4.out_valid), 64'd0);
        tick();
        chk("t6_no_survivor2", 64'(b4.out_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
